// File: rtl/alu32_seq_unit.sv
// alu32_seq_unit: sequenced ALU with valid/ready handshakes and a small result FIFO
//   Optional feature: define ALU32_MUL_EN to make Op 111 an unsigned shift-add
//   multiplier (one operand bit per cycle). Without it, Op 111 returns 0 in one cycle.
//   Ports:
//     clk, rst                   clock, asynchronous active-high reset
//     in_valid/in_ready          request handshake; Op/In1/In2 sampled on accept
//     out_valid/out_ready        result handshake at the FIFO head
//     Out/Zero/Carry             head result, its zero flag, carry / not-borrow
module alu32_seq_unit #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Carry
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH+1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full, pop, slot, accept, push, idle, is_mul, mul_push;
    logic [WIDTH-1:0] alu_res, mul_res, push_res;
    logic             alu_carry, push_carry;
    logic [WIDTH:0]   sum;

    // Op[0] distinguishes SUB from ADD: invert In2 and inject the +1 as carry-in.
    always_comb begin
        sum       = {1'b0, In1} + {1'b0, Op[0] ? ~In2 : In2} + (WIDTH+1)'(Op[0]);
        alu_res   = '0;
        alu_carry = 1'b0;
        case (Op)
            3'b000:         alu_res = In1 & In2;
            3'b001:         alu_res = In1 | In2;
            3'b010:         alu_res = In1 ^ In2;
            3'b011:         alu_res = ~(In1 | In2);
            3'b100, 3'b101: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            3'b110:         alu_res = WIDTH'($signed(In1) < $signed(In2));
            default:        alu_res = '0;
        endcase
    end

`ifdef ALU32_MUL_EN
    localparam int IW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
    logic [IW-1:0]    iter_q, iter_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            iter_q   <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            iter_q   <= iter_d;
        end
    end

    // Only the low WIDTH product bits are kept, so the multiplicand may shift out.
    // After the last iteration the product waits in BUSY until the FIFO has room.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        iter_d   = iter_q;
        mul_push = 1'b0;
        case (state_q)
            IDLE: if (accept && is_mul) begin
                state_d  = BUSY;
                mcand_d  = In1;
                mplier_d = In2;
                prod_d   = '0;
                iter_d   = '0;
            end
            BUSY: if (iter_q == IW'(WIDTH)) begin
                if (slot) begin
                    mul_push = 1'b1;
                    state_d  = IDLE;
                end
            end else begin
                prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                iter_d   = iter_q + IW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign idle    = state_q == IDLE;
    assign is_mul  = Op == 3'b111;
    assign mul_res = prod_q;
`else
    assign idle     = 1'b1;
    assign is_mul   = 1'b0;
    assign mul_push = 1'b0;
    assign mul_res  = '0;
`endif

    assign full       = count_q == (AW+1)'(FIFO_DEPTH);
    assign out_valid  = count_q != '0;
    assign pop        = out_valid & out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign slot       = !full | pop;
    assign in_ready   = !rst & idle & slot;
    assign accept     = in_valid & in_ready;
    assign push       = (accept & !is_mul) | mul_push;
    assign push_res   = mul_push ? mul_res : alu_res;
    assign push_carry = !mul_push & alu_carry;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entries hold {carry, zero, result}; storage needs no reset since count gates it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {push_carry, push_res == '0, push_res};
    end

    assign {Carry, Zero, Out} = out_valid ? mem_q[rd_ptr_q] : '0;
endmodule
